attex_bus_fabric: RTL and testbench
===================================

ATTEX_BUS_FABRIC -- requirements
Module: attex_bus_fabric

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4: number of decoded slaves, 1..8.
REQ-002 SHALL have parameter SLAVE_BASE, default {24'h320000,24'h310000,24'h300000,24'h000000}: packed per-slave byte base address.
REQ-003 SHALL have parameter SLAVE_MASK, default {24'hFF0000,24'hFF0000,24'hFF0000,24'hC00000}: packed per-slave compare mask.
REQ-004 SHALL have parameter SLAVE_LAT, default {2'd1,2'd0,2'd0,2'd0}: per-slave fixed read latency; 0 means wait for slave_ack.
REQ-005 SHALL have parameter IACK_SLAVE, default 0: slave index that services interrupt acknowledge.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 1023: watchdog limit, 10-bit.
REQ-007 clk30  in  1  system clock.
REQ-008 reset_n  in  1  reset; asynchronous, active-low.
REQ-009 cpu_addr  in  23  word address [23:1].
REQ-010 cpu_as, cpu_uds, cpu_lds, cpu_write_strobe  in  1 each  CPU strobes.
REQ-011 cpu_iack  in  1  interrupt-acknowledge cycle.
REQ-012 slave_dout  in  16*NUM_SLAVES  read data per slave.
REQ-013 slave_ack  in  NUM_SLAVES  per-slave completion pulse.
REQ-014 cs  out  NUM_SLAVES  one-hot chip select.
REQ-015 cpu_din  out  16  registered read data.
REQ-016 cpu_bus_ack, cpu_bus_err  out  1 each  single-cycle termination pulses.
REQ-017 fault_addr  out  24  byte address of last erroring cycle.

Function
REQ-018 Decode SHALL match slave i when (addr_byte & MASK_i)==BASE_i; lowest index wins on overlap.
REQ-019 FSM states SHALL be IDLE, WAIT, ACK, ERR, HOLD.
REQ-020 IDLE->WAIT SHALL occur when cpu_as && (cpu_uds||cpu_lds) and a slave matches; cs latched one-hot in same cycle.
REQ-021 Unmapped strobed access SHALL go IDLE->ERR; ERR asserts cpu_bus_err one cycle, latches fault_addr, ->HOLD.
REQ-022 cpu_iack SHALL force selection of IACK_SLAVE and go directly to ACK, ignoring decode.
REQ-023 WAIT with SLAVE_LAT>0 and read SHALL count LAT cycles, then ->ACK; cpu_bus_ack appears LAT+1 cycles after strobe.
REQ-024 Writes to fixed-latency slaves SHALL go WAIT->ACK after one cycle regardless of LAT.
REQ-025 WAIT with SLAVE_LAT==0 SHALL ->ACK the cycle after selected slave_ack is high; other slaves' acks ignored.
REQ-026 ACK SHALL pulse cpu_bus_ack one cycle with cpu_din = selected slave_dout sampled that cycle, ->HOLD.
REQ-027 HOLD SHALL keep cs asserted until cpu_as deasserts, then ->IDLE with cs=0; never re-ack same cycle.
REQ-028 cpu_as deassert during WAIT SHALL abort to IDLE, cs=0, no ack, no err.
REQ-029 cpu_bus_ack and cpu_bus_err SHALL never be high together.

Reset
REQ-030 reset_n low SHALL asynchronously force IDLE, cs=0, cpu_din=0, cpu_bus_ack=0, cpu_bus_err=0, fault_addr=0, counters=0.
REQ-031 Reset mid-cycle SHALL discard the access; first post-reset cycle decodes afresh.

Configuration
REQ-032 Macro ATTEX_BUS_TIMEOUT_EN defined: WAIT exceeding TIMEOUT_CYCLES cycles SHALL ->ERR (cpu_bus_err, fault_addr latched).
REQ-033 Macro undefined: no watchdog logic; WAIT SHALL persist until ack or cpu_as deassert.

Structure
REQ-034 Package attex_bus_pkg SHALL hold the state enum, slave-index typedef, and default map constants.
REQ-035 Watchdog SHALL be sub-module attex_bus_watchdog (clear, enable, expired), instantiated only under ATTEX_BUS_TIMEOUT_EN.

Verification
REQ-036 Read 0x320010, LAT=1, slave2_dout=16'hA55A -> cs=4'b0100 next cycle, ack 2 cycles after strobe, cpu_din=16'hA55A.
REQ-037 Read 0x300002, slave0 acks 5 cycles later with 16'h1234 -> ack following cycle, one pulse, cpu_din=16'h1234.
REQ-038 Read 0x700000 -> cpu_bus_err one cycle, fault_addr=24'h700000, no ack, cs=0.
REQ-039 Timeout enabled, slave1 never acks -> err after 1023 WAIT cycles, fault_addr=24'h310000; macro off -> no err after 2000 cycles.
REQ-040 cpu_iack with slave0_dout=16'h0042 -> ack next cycle, cpu_din=16'h0042, regardless of cpu_addr.
REQ-041 reset_n low during WAIT -> cs=0 and outputs zero immediately; cpu_as held across reset release yields fresh decode.

Source files
------------

// File: rtl/attex_bus_pkg.sv
// Shared state encoding, slave-index type and default address map for the attex bus fabric.
package attex_bus_pkg;

  localparam int MAX_SLAVES = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_ACK  = 3'd2;
  localparam logic [2:0] ST_ERR  = 3'd3;
  localparam logic [2:0] ST_HOLD = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_WAIT = ST_WAIT,
    S_ACK  = ST_ACK,
    S_ERR  = ST_ERR,
    S_HOLD = ST_HOLD
  } bus_state_e;

  typedef logic [2:0] slave_idx_t;

  localparam int          DEFAULT_NUM_SLAVES = 4;
  localparam logic [95:0] DEFAULT_SLAVE_BASE = {24'h320000, 24'h310000, 24'h300000, 24'h000000};
  localparam logic [95:0] DEFAULT_SLAVE_MASK = {24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hC00000};
  localparam logic [7:0]  DEFAULT_SLAVE_LAT  = {2'd1, 2'd0, 2'd0, 2'd0};

  function automatic logic [MAX_SLAVES-1:0] idx_onehot(input slave_idx_t idx);
    return 8'd1 << idx;
  endfunction

endpackage

// File: rtl/attex_bus_watchdog.sv
// Counts consecutive WAIT cycles and flags when the configured limit is reached.
// Only instantiated when ATTEX_BUS_TIMEOUT_EN is defined.
module attex_bus_watchdog #(
  parameter logic [9:0] LIMIT = 10'd1023
) (
  input  logic clk30,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [9:0] count_reg;

  always_ff @(posedge clk30 or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 10'd1;
    end
  end

  // The count starts at zero in the first WAIT cycle, so LIMIT-1 marks the LIMIT-th cycle.
  assign expired = enable && (count_reg == LIMIT - 10'd1);

endmodule

// File: rtl/attex_bus_fabric.sv
// Address-decoding bus fabric between a 68k-style CPU bus and up to eight slaves.
// Define ATTEX_BUS_TIMEOUT_EN to add a watchdog that errors out stalled WAIT states.
module attex_bus_fabric
  import attex_bus_pkg::*;
#(
  parameter int                       NUM_SLAVES     = DEFAULT_NUM_SLAVES,
  parameter logic [24*NUM_SLAVES-1:0] SLAVE_BASE     = DEFAULT_SLAVE_BASE,
  parameter logic [24*NUM_SLAVES-1:0] SLAVE_MASK     = DEFAULT_SLAVE_MASK,
  parameter logic [2*NUM_SLAVES-1:0]  SLAVE_LAT      = DEFAULT_SLAVE_LAT,
  parameter int                       IACK_SLAVE     = 0,
  parameter logic [9:0]               TIMEOUT_CYCLES = 10'd1023
) (
  input  logic                     clk30,
  input  logic                     reset_n,
  input  logic [23:1]              cpu_addr,
  input  logic                     cpu_as,
  input  logic                     cpu_uds,
  input  logic                     cpu_lds,
  input  logic                     cpu_write_strobe,
  input  logic                     cpu_iack,
  input  logic [16*NUM_SLAVES-1:0] slave_dout,
  input  logic [NUM_SLAVES-1:0]    slave_ack,
  output logic [NUM_SLAVES-1:0]    cs,
  output logic [15:0]              cpu_din,
  output logic                     cpu_bus_ack,
  output logic                     cpu_bus_err,
  output logic [23:0]              fault_addr
);

  localparam logic [MAX_SLAVES-1:0] IACK_ONEHOT = idx_onehot(slave_idx_t'(IACK_SLAVE));

  bus_state_e            state_reg;
  slave_idx_t            sel_idx_reg;
  logic [23:0]           addr_reg;
  logic                  write_reg;
  logic [1:0]            lat_cnt_reg;
  logic [23:0]           addr_byte;
  logic [15:0]           dout_tab [MAX_SLAVES];
  logic [1:0]            lat_tab  [MAX_SLAVES];
  logic [MAX_SLAVES-1:0] ack_vec;
  logic [MAX_SLAVES-1:0] match_vec;
  logic [MAX_SLAVES-1:0] dec_onehot;
  slave_idx_t            dec_idx;
  logic                  dec_hit;
  logic                  wd_expired;

  assign addr_byte = {cpu_addr, 1'b0};

  // Unused table slots read as zero so the selected index can always address an 8-entry table.
  for (genvar gi = 0; gi < MAX_SLAVES; gi++) begin : g_slave
    if (gi < NUM_SLAVES) begin : g_used
      assign dout_tab[gi]  = slave_dout[16*gi +: 16];
      assign lat_tab[gi]   = SLAVE_LAT[2*gi +: 2];
      assign ack_vec[gi]   = slave_ack[gi];
      assign match_vec[gi] = (addr_byte & SLAVE_MASK[24*gi +: 24]) == SLAVE_BASE[24*gi +: 24];
    end else begin : g_unused
      assign dout_tab[gi]  = '0;
      assign lat_tab[gi]   = '0;
      assign ack_vec[gi]   = 1'b0;
      assign match_vec[gi] = 1'b0;
    end
  end

  always_comb begin
    dec_idx = '0;
    for (int i = MAX_SLAVES - 1; i >= 0; i--) begin
      if (match_vec[i]) dec_idx = slave_idx_t'(i);
    end
  end

  assign dec_hit    = |match_vec;
  assign dec_onehot = idx_onehot(dec_idx);

`ifdef ATTEX_BUS_TIMEOUT_EN
  attex_bus_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk30   (clk30),
    .reset_n (reset_n),
    .clear   (state_reg != S_WAIT),
    .enable  (state_reg == S_WAIT),
    .expired (wd_expired)
  );
`else
  logic [9:0] timeout_unused;
  assign timeout_unused = TIMEOUT_CYCLES;
  assign wd_expired     = 1'b0;
`endif

  always_ff @(posedge clk30 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      sel_idx_reg <= '0;
      addr_reg    <= '0;
      write_reg   <= 1'b0;
      lat_cnt_reg <= '0;
      cs          <= '0;
      cpu_din     <= '0;
      cpu_bus_ack <= 1'b0;
      cpu_bus_err <= 1'b0;
      fault_addr  <= '0;
    end else begin
      cpu_bus_ack <= 1'b0;
      cpu_bus_err <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          lat_cnt_reg <= '0;
          if (cpu_as && cpu_iack) begin
            sel_idx_reg <= slave_idx_t'(IACK_SLAVE);
            cs          <= IACK_ONEHOT[NUM_SLAVES-1:0];
            addr_reg    <= addr_byte;
            write_reg   <= 1'b0;
            state_reg   <= S_ACK;
          end else if (cpu_as && (cpu_uds || cpu_lds)) begin
            addr_reg  <= addr_byte;
            write_reg <= cpu_write_strobe;
            if (dec_hit) begin
              sel_idx_reg <= dec_idx;
              cs          <= dec_onehot[NUM_SLAVES-1:0];
              state_reg   <= S_WAIT;
            end else begin
              state_reg <= S_ERR;
            end
          end
        end
        S_WAIT: begin
          if (!cpu_as) begin
            cs        <= '0;
            state_reg <= S_IDLE;
          end else if (lat_tab[sel_idx_reg] != 2'd0) begin
            // Fixed-latency slaves accept writes immediately; reads wait out the latency.
            if (write_reg || (lat_cnt_reg == lat_tab[sel_idx_reg] - 2'd1)) begin
              state_reg <= S_ACK;
            end else begin
              lat_cnt_reg <= lat_cnt_reg + 2'd1;
            end
          end else if (ack_vec[sel_idx_reg]) begin
            state_reg <= S_ACK;
          end else if (wd_expired) begin
            cs        <= '0;
            state_reg <= S_ERR;
          end
        end
        S_ACK: begin
          cpu_bus_ack <= 1'b1;
          cpu_din     <= dout_tab[sel_idx_reg];
          state_reg   <= S_HOLD;
        end
        S_ERR: begin
          cpu_bus_err <= 1'b1;
          fault_addr  <= addr_reg;
          cs          <= '0;
          state_reg   <= S_HOLD;
        end
        S_HOLD: begin
          if (!cpu_as) begin
            cs        <= '0;
            state_reg <= S_IDLE;
          end
        end
        default: begin
          cs        <= '0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_attex_bus_fabric.sv
// Scoreboard bench for attex_bus_fabric: a driver pushes expected terminations computed
// from the address map, and a monitor pops and compares them whenever ack or err pulses.
module tb_attex_bus_fabric;

  localparam int NS      = 4;
  localparam int IACK    = 0;
  localparam int TIMEOUT = 1023;

  // Map with three 64 KB windows, a catch-all low region, and two fixed-latency devices.
  logic [23:0] base_m [NS] = '{24'h300000, 24'h310000, 24'h320000, 24'h000000};
  logic [23:0] mask_m [NS] = '{24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hC00000};
  int          lat_m  [NS] = '{0, 0, 1, 3};

  logic          clk30 = 1'b0;
  logic          reset_n = 1'b0;
  logic [23:1]   cpu_addr = '0;
  logic          cpu_as = 1'b0, cpu_uds = 1'b0, cpu_lds = 1'b0;
  logic          cpu_write_strobe = 1'b0, cpu_iack = 1'b0;
  logic [16*NS-1:0] slave_dout = '0;
  logic [NS-1:0] slave_ack = '0;
  logic [NS-1:0] cs;
  logic [15:0]   cpu_din;
  logic          cpu_bus_ack, cpu_bus_err;
  logic [23:0]   fault_addr;

  typedef struct {
    bit          is_err;
    int          cyc;
    logic [15:0] din;
    bit          chk_din;
    logic [3:0]  cs;
    logic [23:0] fault;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   out_count = 0;
  logic [15:0] dout_m [NS];

  attex_bus_fabric #(
    .NUM_SLAVES     (NS),
    .SLAVE_BASE     ({24'h000000, 24'h320000, 24'h310000, 24'h300000}),
    .SLAVE_MASK     ({24'hC00000, 24'hFF0000, 24'hFF0000, 24'hFF0000}),
    .SLAVE_LAT      ({2'd3, 2'd1, 2'd0, 2'd0}),
    .IACK_SLAVE     (IACK),
    .TIMEOUT_CYCLES (10'd1023)
  ) dut (
    .clk30            (clk30),
    .reset_n          (reset_n),
    .cpu_addr         (cpu_addr),
    .cpu_as           (cpu_as),
    .cpu_uds          (cpu_uds),
    .cpu_lds          (cpu_lds),
    .cpu_write_strobe (cpu_write_strobe),
    .cpu_iack         (cpu_iack),
    .slave_dout       (slave_dout),
    .slave_ack        (slave_ack),
    .cs               (cs),
    .cpu_din          (cpu_din),
    .cpu_bus_ack      (cpu_bus_ack),
    .cpu_bus_err      (cpu_bus_err),
    .fault_addr       (fault_addr)
  );

  always #5 clk30 = ~clk30;
  always @(posedge clk30) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_decode(input logic [23:0] ab);
    for (int i = 0; i < NS; i++) begin
      if ((ab & mask_m[i]) == base_m[i]) return i;
    end
    return -1;
  endfunction

  // Monitor: every termination pulse must match the head of the expectation queue.
  always @(negedge clk30) begin
    if (reset_n && (cpu_bus_ack || cpu_bus_err)) begin
      exp_t e;
      out_count++;
      check("ack_err_exclusive", {31'd0, cpu_bus_ack & cpu_bus_err}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_termination", {31'd0, cpu_bus_ack | cpu_bus_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        $display("txn %0d: %s at cycle %0d din=%04h cs=%b fault=%06h", out_count,
                 cpu_bus_err ? "err" : "ack", cyc, cpu_din, cs, fault_addr);
        check("term_kind_err", {31'd0, cpu_bus_err}, {31'd0, e.is_err});
        check("term_cycle", cyc, e.cyc);
        check("term_cs", {28'd0, cs}, {28'd0, e.cs});
        if (e.chk_din) check("read_data", {16'd0, cpu_din}, {16'd0, e.din});
        if (e.is_err) check("fault_addr", {8'd0, fault_addr}, {8'd0, e.fault});
      end
    end
  end

  task automatic drive_strobe(input logic [23:0] a, input bit wr, input bit iack);
    cpu_addr         = a[23:1];
    cpu_as           = 1'b1;
    cpu_uds          = 1'b1;
    cpu_lds          = 1'b1;
    cpu_write_strobe = wr;
    cpu_iack         = iack;
  endtask

  task automatic release_bus();
    cpu_as = 1'b0; cpu_uds = 1'b0; cpu_lds = 1'b0;
    cpu_write_strobe = 1'b0; cpu_iack = 1'b0;
  endtask

  // Called right after a falling edge: issues one access and follows it to completion.
  task automatic run_access(input logic [23:0] a, input bit wr, input bit iack, input int ackdly,
                            input logic [15:0] d, input bit no_ack, input int budget);
    exp_t e;
    int idx, c0, k;
    bit seen, use_ack;
    logic [3:0] selmask;
    logic [23:0] ab;
    ab  = {a[23:1], 1'b0};
    idx = iack ? IACK : model_decode(ab);
    for (int s = 0; s < NS; s++) dout_m[s] = (s == idx) ? d : 16'($urandom);
    slave_dout = {dout_m[3], dout_m[2], dout_m[1], dout_m[0]};
    drive_strobe(a, wr, iack);
    c0      = cyc + 1;
    selmask = (idx >= 0) ? 4'(1 << idx) : 4'd0;
    use_ack = (idx >= 0) && !iack && (lat_m[idx] == 0) && !no_ack;
    e.is_err = 0; e.din = d; e.chk_din = !wr; e.cs = selmask; e.fault = '0;
    if (idx < 0) begin
      e.is_err = 1; e.cyc = c0 + 1; e.cs = '0; e.fault = ab; e.chk_din = 0;
    end else if (iack) begin
      e.cyc = c0 + 1;
    end else if (lat_m[idx] > 0) begin
      e.cyc = c0 + (wr ? 1 : lat_m[idx]) + 1;
    end else if (no_ack) begin
      e.is_err = 1; e.cyc = c0 + TIMEOUT + 1; e.cs = '0; e.fault = ab; e.chk_din = 0;
    end else begin
      e.cyc = c0 + ackdly + 1;
    end
    exp_q.push_back(e);
    k = 0; seen = 0;
    while (!seen && k < budget) begin
      @(negedge clk30);
      k++;
      slave_ack = (4'($urandom) & ~selmask) | ((use_ack && k == ackdly) ? selmask : 4'd0);
      if (cpu_bus_ack || cpu_bus_err) seen = 1;
    end
    slave_ack = '0;
    check("completed_within_budget", {31'd0, seen}, 32'd1);
    @(negedge clk30);
    check("hold_cs", {28'd0, cs}, {28'd0, e.cs});
    release_bus();
    @(negedge clk30);
    check("idle_cs", {28'd0, cs}, 32'd0);
  endtask

  initial begin
    logic [23:0] a;
    int n0;
    bit wr, ia;

    repeat (3) @(negedge clk30);
    check("reset_cs", {28'd0, cs}, 32'd0);
    check("reset_din", {16'd0, cpu_din}, 32'd0);
    check("reset_ack", {31'd0, cpu_bus_ack}, 32'd0);
    check("reset_err", {31'd0, cpu_bus_err}, 32'd0);
    check("reset_fault", {8'd0, fault_addr}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk30);

    // Fixed-latency read, ack-driven read, unmapped access, interrupt acknowledge.
    run_access(24'h320010, 0, 0, 0, 16'hA55A, 0, 20);
    @(negedge clk30); run_access(24'h300002, 0, 0, 5, 16'h1234, 0, 20);
    @(negedge clk30); run_access(24'h700000, 0, 0, 0, 16'h0000, 0, 20);
    @(negedge clk30); run_access(24'($urandom) & 24'hFFFFFE, 0, 1, 0, 16'h0042, 0, 20);
    // Writes to fixed-latency slaves complete after one WAIT cycle.
    @(negedge clk30); run_access(24'h320000, 1, 0, 0, 16'h0000, 0, 20);
    @(negedge clk30); run_access(24'h100000, 1, 0, 0, 16'h0000, 0, 20);
    @(negedge clk30); run_access(24'h100000, 0, 0, 0, 16'hBEEF, 0, 20);

    // Address strobe dropped mid-WAIT: no termination, chip select released.
    @(negedge clk30);
    drive_strobe(24'h300004, 0, 0);
    n0 = out_count;
    repeat (3) @(negedge clk30);
    check("abort_cs_during_wait", {28'd0, cs}, 32'd1);
    release_bus();
    @(negedge clk30);
    check("abort_cs", {28'd0, cs}, 32'd0);
    repeat (3) @(negedge clk30);
    check("abort_no_termination", out_count, n0);

    // Slave that never acknowledges.
`ifdef ATTEX_BUS_TIMEOUT_EN
    @(negedge clk30); run_access(24'h310000, 0, 0, 0, 16'h0000, 1, TIMEOUT + 20);
`else
    @(negedge clk30);
    drive_strobe(24'h310000, 0, 0);
    n0 = out_count;
    repeat (2000) @(negedge clk30);
    check("no_watchdog_termination", out_count, n0);
    check("stall_cs", {28'd0, cs}, 32'd2);
    release_bus();
    @(negedge clk30);
    check("stall_release_cs", {28'd0, cs}, 32'd0);
`endif

    // Reset during WAIT clears everything at once; the held strobe is decoded afresh.
    @(negedge clk30); run_access(24'h700000, 0, 0, 0, 16'h0000, 0, 20);
    @(negedge clk30);
    drive_strobe(24'h300002, 0, 0);
    repeat (2) @(negedge clk30);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_cs", {28'd0, cs}, 32'd0);
    check("async_reset_fault", {8'd0, fault_addr}, 32'd0);
    check("async_reset_din", {16'd0, cpu_din}, 32'd0);
    check("async_reset_ack", {31'd0, cpu_bus_ack | cpu_bus_err}, 32'd0);
    @(negedge clk30);
    @(negedge clk30);
    reset_n = 1'b1;
    run_access(24'h300002, 0, 0, 2, 16'h5AA5, 0, 20);

    // Randomised traffic across every region, direction and acknowledge delay.
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 4))
        0: a = 24'h300000 | 24'($urandom_range(0, 'hFFFF));
        1: a = 24'h310000 | 24'($urandom_range(0, 'hFFFF));
        2: a = 24'h320000 | 24'($urandom_range(0, 'hFFFF));
        3: a = 24'($urandom_range(0, 'h3FFFFF));
        default: a = 24'($urandom_range('h400000, 'hFFFFFF));
      endcase
      a[0] = 1'b0;
      ia = ($urandom_range(0, 7) == 0);
      wr = ia ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk30);
      run_access(a, wr, ia, $urandom_range(1, 6), 16'($urandom), 0, 30);
    end

    repeat (3) @(negedge clk30);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
